pcie_tx_rd: RTL and testbench

- DMA read-request transmitter: converts internal DMA read requests into PCIe Memory Read (MRd) TLPs on the 64-bit endpoint TRN transmit interface.
- Splits requests at MAX_RD_DW and at 4 KB host boundaries.
- Takes tags from the outstanding-request table (ORT) and registers each issued tag with its destination (iface/mem/addr).
- Completion data for these tags is steered by the pcie_rx_cm path.

---
 rtl/pcie_tx_rd.sv | 184 ++++++++++++++++++
 tb/tb_pcie_tx_rd.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_tx_rd.sv
// rtl/pcie_tx_rd.sv - DMA read request to PCIe MRd TLP transmitter on the 64-bit TRN interface
`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 16
`endif

module pcie_tx_rd #(
    parameter int MAX_RD_DW     = 128,
    parameter int MEM_ADDR_BITS = `MEM_ADDR_BITS
) (
    input  logic                     pcie_clk,
    input  logic                     rst_n,
    input  logic                     rd_req_v,
    output logic                     rd_req_rdy,
    input  logic [63:0]              rd_req_host_addr,
    input  logic [10:0]              rd_req_len_dw,
    input  logic [1:0]               rd_req_iface,
    input  logic [3:0]               rd_req_mem,
    input  logic [MEM_ADDR_BITS-1:0] rd_req_addr,
    input  logic [7:0]               cfg_bus_number,
    input  logic [4:0]               cfg_device_number,
    input  logic [2:0]               cfg_function_number,
    input  logic                     ort_next_tag_v,
    input  logic [3:0]               ort_next_tag,
    output logic                     ort_req_v,
    output logic [3:0]               ort_req_tag,
    output logic [1:0]               ort_req_iface,
    output logic [3:0]               ort_req_mem,
    output logic [MEM_ADDR_BITS-1:0] ort_req_addr,
    output logic                     tx_req,
    input  logic                     tx_gnt,
    output logic [63:0]              trn_td,
    output logic [7:0]               trn_trem_n,
    output logic                     trn_tsof_n,
    output logic                     trn_teof_n,
    output logic                     trn_tsrc_rdy_n,
    output logic                     trn_tsrc_dsc_n,
    input  logic                     trn_tdst_rdy_n,
    input  logic [5:0]               trn_tbuf_av,
    output logic [31:0]              stat_pcie_tx_rd_cnt,
    output logic [31:0]              stat_pcie_tx_err_cnt
);

    typedef enum logic [2:0] {IDLE, CHUNK, WAIT, HDR0, HDR1} state_t;

    state_t                   state;
    logic                     out_of_reset;
    logic [63:0]              host_addr;
    logic [10:0]              remaining;
    logic [10:0]              chunk;
    logic [1:0]               dst_iface;
    logic [3:0]               dst_mem;
    logic [MEM_ADDR_BITS-1:0] dst_addr;
    logic [3:0]               tag;
    logic [63:0]              hdr1_td;
    logic [7:0]               hdr1_trem;

    // Only the non-posted buffer flag and DW-aligned address bits matter
    logic unused_inputs;
    assign unused_inputs = &{1'b0, trn_tbuf_av[5:1], rd_req_host_addr[1:0]};

    // Chunk size: smallest of remaining length, MRd limit and DWs left in the 4 KB page
    logic [12:0] page_bytes;
    logic [10:0] page_dw;
    logic [10:0] max_dw;
    logic [10:0] chunk_next;
    always_comb begin
        page_bytes = 13'd4096 - {1'b0, host_addr[11:0]};
        page_dw    = page_bytes[12:2];
        max_dw     = 11'(MAX_RD_DW);
        chunk_next = remaining;
        if (max_dw < chunk_next)  chunk_next = max_dw;
        if (page_dw < chunk_next) chunk_next = page_dw;
    end

    // Header fields for the current chunk; 1024 DW wraps to a zero length field
    logic        is_4dw;
    logic [31:0] dw0;
    logic [31:0] dw1;
    always_comb begin
        is_4dw = |host_addr[63:32];
        dw0    = {1'b0, (is_4dw ? 2'b01 : 2'b00), 5'b00000, 1'b0, 3'b000, 4'b0000,
                  1'b0, 1'b0, 2'b00, 2'b00, chunk[9:0]};
        dw1    = {cfg_bus_number, cfg_device_number, cfg_function_number, 4'b0000,
                  ort_next_tag, ((chunk == 11'd1) ? 4'h0 : 4'hF), 4'hF};
    end

    assign rd_req_rdy     = (state == IDLE) & out_of_reset;
    assign tx_req         = ((state == WAIT) & ort_next_tag_v & trn_tbuf_av[0]) |
                            (state == HDR0) | (state == HDR1);
    assign trn_tsrc_dsc_n = 1'b1;

    // Request splitting FSM with registered TRN beats and ORT registration
    always_ff @(posedge pcie_clk or negedge rst_n) begin
        if (!rst_n) begin
            state                <= IDLE;
            out_of_reset         <= 1'b0;
            host_addr            <= '0;
            remaining            <= '0;
            chunk                <= '0;
            dst_iface            <= '0;
            dst_mem              <= '0;
            dst_addr             <= '0;
            tag                  <= '0;
            hdr1_td              <= '0;
            hdr1_trem            <= '0;
            ort_req_v            <= 1'b0;
            ort_req_tag          <= '0;
            ort_req_iface        <= '0;
            ort_req_mem          <= '0;
            ort_req_addr         <= '0;
            trn_td               <= '0;
            trn_trem_n           <= '0;
            trn_tsof_n           <= 1'b1;
            trn_teof_n           <= 1'b1;
            trn_tsrc_rdy_n       <= 1'b1;
            stat_pcie_tx_rd_cnt  <= '0;
            stat_pcie_tx_err_cnt <= '0;
        end else begin
            out_of_reset <= 1'b1;
            ort_req_v    <= 1'b0;
            case (state)
                IDLE: begin
                    if (rd_req_v && rd_req_rdy) begin
                        host_addr <= {rd_req_host_addr[63:2], 2'b00};
                        remaining <= rd_req_len_dw;
                        dst_iface <= rd_req_iface;
                        dst_mem   <= rd_req_mem;
                        dst_addr  <= rd_req_addr;
                        if (rd_req_len_dw == 11'd0)
                            stat_pcie_tx_err_cnt <= stat_pcie_tx_err_cnt + 32'd1;
                        else
                            state <= CHUNK;
                    end
                end
                CHUNK: begin
                    chunk <= chunk_next;
                    state <= WAIT;
                end
                WAIT: begin
                    if (tx_req && tx_gnt) begin
                        tag            <= ort_next_tag;
                        trn_td         <= {dw0, dw1};
                        trn_trem_n     <= 8'h00;
                        trn_tsof_n     <= 1'b0;
                        trn_tsrc_rdy_n <= 1'b0;
                        hdr1_td        <= is_4dw ? {host_addr[63:32], host_addr[31:2], 2'b00}
                                                 : {host_addr[31:2], 2'b00, 32'h0};
                        hdr1_trem      <= is_4dw ? 8'h00 : 8'h0F;
                        state          <= HDR0;
                    end
                end
                HDR0: begin
                    if (!trn_tdst_rdy_n) begin
                        ort_req_v     <= 1'b1;
                        ort_req_tag   <= tag;
                        ort_req_iface <= dst_iface;
                        ort_req_mem   <= dst_mem;
                        ort_req_addr  <= dst_addr;
                        trn_td        <= hdr1_td;
                        trn_trem_n    <= hdr1_trem;
                        trn_tsof_n    <= 1'b1;
                        trn_teof_n    <= 1'b0;
                        state         <= HDR1;
                    end
                end
                HDR1: begin
                    if (!trn_tdst_rdy_n) begin
                        trn_td              <= '0;
                        trn_trem_n          <= '0;
                        trn_teof_n          <= 1'b1;
                        trn_tsrc_rdy_n      <= 1'b1;
                        stat_pcie_tx_rd_cnt <= stat_pcie_tx_rd_cnt + 32'd1;
                        host_addr           <= host_addr + {51'b0, chunk, 2'b00};
                        dst_addr            <= dst_addr + MEM_ADDR_BITS'(chunk);
                        remaining           <= remaining - chunk;
                        state               <= (remaining == chunk) ? IDLE : CHUNK;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pcie_tx_rd.sv
// tb/tb_pcie_tx_rd.sv - directed self-checking bench for pcie_tx_rd
module tb_pcie_tx_rd;

    logic        clk;
    logic        rst_n;
    logic        rd_req_v;
    logic        rd_req_rdy;
    logic [63:0] rd_req_host_addr;
    logic [10:0] rd_req_len_dw;
    logic [1:0]  rd_req_iface;
    logic [3:0]  rd_req_mem;
    logic [15:0] rd_req_addr;
    logic [7:0]  cfg_bus_number;
    logic [4:0]  cfg_device_number;
    logic [2:0]  cfg_function_number;
    logic        ort_next_tag_v;
    logic [3:0]  ort_next_tag;
    logic        ort_req_v;
    logic [3:0]  ort_req_tag;
    logic [1:0]  ort_req_iface;
    logic [3:0]  ort_req_mem;
    logic [15:0] ort_req_addr;
    logic        tx_req;
    logic        tx_gnt;
    logic [63:0] trn_td;
    logic [7:0]  trn_trem_n;
    logic        trn_tsof_n;
    logic        trn_teof_n;
    logic        trn_tsrc_rdy_n;
    logic        trn_tsrc_dsc_n;
    logic        trn_tdst_rdy_n;
    logic [5:0]  trn_tbuf_av;
    logic [31:0] stat_pcie_tx_rd_cnt;
    logic [31:0] stat_pcie_tx_err_cnt;

    int vectors = 0;
    int miscompares = 0;

    logic [63:0] beat_td[$];
    logic [7:0]  beat_trem[$];
    logic        beat_sof[$];
    logic        beat_eof[$];
    logic [3:0]  ort_tags[$];
    logic [15:0] ort_addrs[$];
    logic [5:0]  ort_dest[$];
    int          ort_cnt = 0;
    logic [3:0]  tag_base;
    logic [3:0]  ort_cnt_lo;

    assign ort_cnt_lo   = 4'(ort_cnt);
    assign ort_next_tag = tag_base + ort_cnt_lo;

    pcie_tx_rd #(.MAX_RD_DW(128), .MEM_ADDR_BITS(16)) dut (
        .pcie_clk(clk), .rst_n(rst_n),
        .rd_req_v(rd_req_v), .rd_req_rdy(rd_req_rdy),
        .rd_req_host_addr(rd_req_host_addr), .rd_req_len_dw(rd_req_len_dw),
        .rd_req_iface(rd_req_iface), .rd_req_mem(rd_req_mem), .rd_req_addr(rd_req_addr),
        .cfg_bus_number(cfg_bus_number), .cfg_device_number(cfg_device_number),
        .cfg_function_number(cfg_function_number),
        .ort_next_tag_v(ort_next_tag_v), .ort_next_tag(ort_next_tag),
        .ort_req_v(ort_req_v), .ort_req_tag(ort_req_tag), .ort_req_iface(ort_req_iface),
        .ort_req_mem(ort_req_mem), .ort_req_addr(ort_req_addr),
        .tx_req(tx_req), .tx_gnt(tx_gnt),
        .trn_td(trn_td), .trn_trem_n(trn_trem_n), .trn_tsof_n(trn_tsof_n),
        .trn_teof_n(trn_teof_n), .trn_tsrc_rdy_n(trn_tsrc_rdy_n),
        .trn_tsrc_dsc_n(trn_tsrc_dsc_n), .trn_tdst_rdy_n(trn_tdst_rdy_n),
        .trn_tbuf_av(trn_tbuf_av),
        .stat_pcie_tx_rd_cnt(stat_pcie_tx_rd_cnt), .stat_pcie_tx_err_cnt(stat_pcie_tx_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every accepted TRN beat and every ORT registration pulse
    always @(posedge clk) begin
        if (rst_n && !trn_tsrc_rdy_n && !trn_tdst_rdy_n) begin
            beat_td.push_back(trn_td);
            beat_trem.push_back(trn_trem_n);
            beat_sof.push_back(trn_tsof_n);
            beat_eof.push_back(trn_teof_n);
        end
        if (rst_n && ort_req_v) begin
            ort_tags.push_back(ort_req_tag);
            ort_addrs.push_back(ort_req_addr);
            ort_dest.push_back({ort_req_iface, ort_req_mem});
            ort_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [63:0] a, input logic [10:0] len,
                         input logic [1:0] ifc, input logic [3:0] mem, input logic [15:0] da);
        rd_req_host_addr = a;
        rd_req_len_dw    = len;
        rd_req_iface     = ifc;
        rd_req_mem       = mem;
        rd_req_addr      = da;
        rd_req_v         = 1'b1;
        step();
        rd_req_v         = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (!rd_req_rdy && n < budget) begin
            step();
            n++;
        end
        chk(tag, {63'b0, rd_req_rdy}, 64'd1);
    endtask

    int nb;
    int no;
    logic [63:0] held;
    int n;
    logic [10:0] exp_len[4]  = '{11'd4, 11'd128, 11'd128, 11'd40};
    logic [31:0] exp_ha[4]   = '{32'h0FF0, 32'h1000, 32'h1200, 32'h1400};
    logic [15:0] exp_da[4]   = '{16'h0200, 16'h0204, 16'h0284, 16'h0304};

    initial begin
        rst_n = 1'b0;
        rd_req_v = 1'b0;
        rd_req_host_addr = '0;
        rd_req_len_dw = '0;
        rd_req_iface = '0;
        rd_req_mem = '0;
        rd_req_addr = '0;
        cfg_bus_number = 8'd3;
        cfg_device_number = 5'd0;
        cfg_function_number = 3'd0;
        ort_next_tag_v = 1'b1;
        tag_base = 4'd5;
        tx_gnt = 1'b1;
        trn_tdst_rdy_n = 1'b0;
        trn_tbuf_av = 6'h3F;

        // Reset values
        step();
        step();
        chk("rst_ctl", {tx_req, ort_req_v, rd_req_rdy, trn_tsof_n, trn_teof_n,
                        trn_tsrc_rdy_n, trn_tsrc_dsc_n}, 64'b0001111);
        chk("rst_td", trn_td, 64'h0);
        chk("rst_trem", {56'b0, trn_trem_n}, 64'h0);
        chk("rst_stats", {stat_pcie_tx_rd_cnt, stat_pcie_tx_err_cnt}, 64'h0);
        rst_n = 1'b1;
        chk("rdy_before_edge", {63'b0, rd_req_rdy}, 64'd0);
        step();
        chk("rdy_after_edge", {63'b0, rd_req_rdy}, 64'd1);

        // 3DW single read
        nb = beat_td.size();
        no = ort_cnt;
        issue(64'h0000_0000_1000_0040, 11'd16, 2'd1, 4'd2, 16'h0100);
        wait_idle("t1_done", 50);
        chk("t1_nbeats", 64'(beat_td.size() - nb), 64'd2);
        chk("t1_nort", 64'(ort_cnt - no), 64'd1);
        if (beat_td.size() >= nb + 2) begin
            chk("t1_beat0", beat_td[nb], 64'h00000010_030005FF);
            chk("t1_sof", {62'b0, beat_sof[nb], beat_eof[nb]}, 64'b01);
            chk("t1_beat1", beat_td[nb+1], 64'h10000040_00000000);
            chk("t1_trem", {56'b0, beat_trem[nb+1]}, 64'h0F);
            chk("t1_eof", {62'b0, beat_sof[nb+1], beat_eof[nb+1]}, 64'b10);
        end
        if (ort_cnt > no) begin
            chk("t1_tag", {60'b0, ort_tags[no]}, 64'd5);
            chk("t1_dest", {42'b0, ort_dest[no], ort_addrs[no]}, {42'b0, 6'b01_0010, 16'h0100});
        end
        chk("t1_rdcnt", {32'b0, stat_pcie_tx_rd_cnt}, 64'd1);

        // 4DW single-DW read
        nb = beat_td.size();
        issue(64'h0000_0001_0000_0000, 11'd1, 2'd0, 4'd0, 16'h0000);
        wait_idle("t2_done", 50);
        chk("t2_nbeats", 64'(beat_td.size() - nb), 64'd2);
        if (beat_td.size() >= nb + 2) begin
            chk("t2_beat0", beat_td[nb], 64'h20000001_0300060F);
            chk("t2_beat1", beat_td[nb+1], 64'h00000001_00000000);
            chk("t2_trem", {56'b0, beat_trem[nb+1]}, 64'h00);
        end
        chk("t2_rdcnt", {32'b0, stat_pcie_tx_rd_cnt}, 64'd2);

        // Split at 4 KB boundary and at MAX_RD_DW
        nb = beat_td.size();
        no = ort_cnt;
        issue(64'h0000_0000_0000_0FF0, 11'd300, 2'd2, 4'd7, 16'h0200);
        wait_idle("t3_done", 300);
        chk("t3_nbeats", 64'(beat_td.size() - nb), 64'd8);
        chk("t3_nort", 64'(ort_cnt - no), 64'd4);
        if (beat_td.size() >= nb + 8 && ort_cnt >= no + 4) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("t3_len%0d", i), {54'b0, beat_td[nb+2*i][41:32]}, {54'b0, exp_len[i][9:0]});
                chk($sformatf("t3_addr%0d", i), {32'b0, beat_td[nb+2*i+1][63:32]}, {32'b0, exp_ha[i]});
                chk($sformatf("t3_dest%0d", i), {48'b0, ort_addrs[no+i]}, {48'b0, exp_da[i]});
                chk($sformatf("t3_tag%0d", i), {60'b0, ort_tags[no+i]}, 64'(7 + i));
            end
        end
        chk("t3_rdcnt", {32'b0, stat_pcie_tx_rd_cnt}, 64'd6);

        // Flow control gates and backpressure
        nb = beat_td.size();
        no = ort_cnt;
        ort_next_tag_v = 1'b0;
        issue(64'h0000_0000_0000_2000, 11'd8, 2'd0, 4'd1, 16'h0040);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t4_no_tag_req", {63'b0, tx_req}, 64'd0);
        end
        ort_next_tag_v = 1'b1;
        trn_tbuf_av = 6'h3E;
        trn_tdst_rdy_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t4_no_buf_req", {63'b0, tx_req}, 64'd0);
        end
        trn_tbuf_av = 6'h3F;
        n = 0;
        while (trn_tsrc_rdy_n && n < 20) begin
            step();
            n++;
        end
        chk("t4_hdr0_start", {63'b0, trn_tsrc_rdy_n}, 64'd0);
        held = trn_td;
        chk("t4_hdr0_val", held, 64'h00000008_03000BFF);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_hdr0_hold", {trn_td[63:3], trn_tsof_n, trn_tsrc_rdy_n, tx_req},
                                {held[63:3], 1'b0, 1'b0, 1'b1});
            chk("t4_no_early_ort", {63'b0, ort_req_v}, 64'd0);
        end
        trn_tdst_rdy_n = 1'b0;
        step();
        trn_tdst_rdy_n = 1'b1;
        chk("t4_ort_pulse", {63'b0, ort_req_v}, 64'd1);
        held = trn_td;
        chk("t4_hdr1_val", held, 64'h00002000_00000000);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_hdr1_hold", {trn_td[63:3], trn_teof_n, trn_tsrc_rdy_n, ort_req_v},
                                {held[63:3], 1'b0, 1'b0, 1'b0});
        end
        trn_tdst_rdy_n = 1'b0;
        step();
        wait_idle("t4_done", 20);
        chk("t4_nbeats", 64'(beat_td.size() - nb), 64'd2);
        chk("t4_nort", 64'(ort_cnt - no), 64'd1);

        // Zero-length request is dropped
        nb = beat_td.size();
        no = ort_cnt;
        issue(64'h0000_0000_0000_4000, 11'd0, 2'd0, 4'd0, 16'h0000);
        chk("t5_idle_next", {63'b0, rd_req_rdy}, 64'd1);
        chk("t5_errcnt", {32'b0, stat_pcie_tx_err_cnt}, 64'd1);
        repeat (5) step();
        chk("t5_no_tlp", {32'(beat_td.size() - nb), 32'(ort_cnt - no)}, 64'd0);
        chk("t5_no_req", {62'b0, tx_req, trn_tsrc_rdy_n}, 64'b01);

        // Asynchronous reset in the middle of HDR1
        issue(64'h0000_0000_0000_3000, 11'd4, 2'd0, 4'd0, 16'h0000);
        n = 0;
        while (trn_teof_n && n < 20) begin
            step();
            n++;
        end
        chk("t6_in_hdr1", {63'b0, trn_teof_n}, 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_ctl", {tx_req, ort_req_v, rd_req_rdy, trn_tsof_n, trn_teof_n,
                           trn_tsrc_rdy_n, trn_tsrc_dsc_n}, 64'b0001111);
        chk("t6_rst_td", {trn_td, trn_trem_n}, 72'h0);
        chk("t6_rst_stats", {stat_pcie_tx_rd_cnt, stat_pcie_tx_err_cnt}, 64'h0);
        step();
        rst_n = 1'b1;
        chk("t6_rdy_low", {63'b0, rd_req_rdy}, 64'd0);
        step();
        chk("t6_rdy_high", {63'b0, rd_req_rdy}, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
